// File: rtl/dmem_unit.sv
// dmem_unit: multi-cycle data memory for the MEM stage of the 64-bit RISC-V pipeline.
// Supports byte/half/word/doubleword loads and stores with sign or zero extension,
// flags misaligned and out-of-range accesses, and models a configurable access latency
// behind a valid/ready request handshake. busy lets the hazard unit freeze the pipeline.
module dmem_unit #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   output logic [63:0] resp_rdata,
   output logic [1:0]  resp_err,
   output logic        busy
);

   localparam int IDX_W = $clog2(DEPTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]       state;
   logic [3:0]       cnt;
   logic             lat_write;
   logic [1:0]       lat_size;
   logic             lat_unsigned;
   logic [IDX_W-1:0] lat_idx;
   logic [2:0]       lat_off;
   logic [63:0]      lat_wdata;

   logic [63:0]      mem [DEPTH];

   logic             misaligned;
   logic             out_of_range;
   logic [1:0]       req_err;
   logic             commit;
   logic [7:0]       byte_en;
   logic [63:0]      wdata_sh;
   logic [63:0]      rd_sh;
   logic [63:0]      ld_data;

   assign req_ready  = (state == ST_IDLE);
   assign busy       = (state != ST_IDLE);
   assign resp_valid = (state == ST_RESP);
   assign commit     = (state == ST_BUSY) && (cnt == 4'd0);

   // Classify the incoming request; only meaningful on the accept edge
   always_comb begin
      misaligned = 1'b0;
      case (req_size)
         2'b01:   misaligned = req_addr[0];
         2'b10:   misaligned = |req_addr[1:0];
         2'b11:   misaligned = |req_addr[2:0];
         default: misaligned = 1'b0;
      endcase
      out_of_range = (req_addr[63:3] >= 61'(DEPTH));
      req_err      = {out_of_range, misaligned};
   end

   // Lane selection for stores and lane extraction plus extension for loads
   always_comb begin
      byte_en = 8'h00;
      ld_data = 64'd0;
      case (lat_size)
         2'b00:   byte_en = 8'(8'h01 << lat_off);
         2'b01:   byte_en = 8'(8'h03 << lat_off);
         2'b10:   byte_en = 8'(8'h0F << lat_off);
         default: byte_en = 8'hFF;
      endcase
      wdata_sh = lat_wdata << {lat_off, 3'b000};
      rd_sh    = mem[lat_idx] >> {lat_off, 3'b000};
      case (lat_size)
         2'b00:   ld_data = lat_unsigned ? {56'd0, rd_sh[7:0]}
                                         : {{56{rd_sh[7]}}, rd_sh[7:0]};
         2'b01:   ld_data = lat_unsigned ? {48'd0, rd_sh[15:0]}
                                         : {{48{rd_sh[15]}}, rd_sh[15:0]};
         2'b10:   ld_data = lat_unsigned ? {32'd0, rd_sh[31:0]}
                                         : {{32{rd_sh[31]}}, rd_sh[31:0]};
         default: ld_data = rd_sh;
      endcase
   end

   // Request FSM: accept in IDLE, count down the latency, then present a one-cycle response
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         cnt          <= 4'd0;
         lat_write    <= 1'b0;
         lat_size     <= 2'b00;
         lat_unsigned <= 1'b0;
         lat_idx      <= '0;
         lat_off      <= 3'd0;
         lat_wdata    <= 64'd0;
         resp_rdata   <= 64'd0;
         resp_err     <= 2'b00;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  lat_write    <= req_write;
                  lat_size     <= req_size;
                  lat_unsigned <= req_unsigned;
                  lat_idx      <= req_addr[IDX_W+2:3];
                  lat_off      <= req_addr[2:0];
                  lat_wdata    <= req_wdata;
                  if (req_err != 2'b00) begin
                     state      <= ST_RESP;
                     resp_err   <= req_err;
                     resp_rdata <= 64'd0;
                  end else begin
                     state <= ST_BUSY;
                     cnt   <= 4'(LATENCY - 1);
                  end
               end
            end
            ST_BUSY: begin
               if (cnt == 4'd0) begin
                  state      <= ST_RESP;
                  resp_err   <= 2'b00;
                  resp_rdata <= lat_write ? 64'd0 : ld_data;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Store commit: only the selected byte lanes change, and only on the final BUSY edge
   always_ff @(posedge clock) begin
      if (commit && lat_write) begin
         for (int i = 0; i < 8; i++) begin
            if (byte_en[i]) mem[lat_idx][i*8 +: 8] <= wdata_sh[i*8 +: 8];
         end
      end
   end

endmodule
